spi_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 16-bit SPI master. It accepts single-word register requests from the oscilloscope control logic (write, read, write-with-verify) and formats them into 16-bit SPI commands. It drives the master's `wrt`/`cmd` handshake, waits for `done`, enforces an inter-frame gap, and returns the captured response with status. A timeout watchdog guards against a stalled transfer.

---
 rtl/spi_cmd_seq.sv | 166 ++++++++++++++++
 tb/tb_spi_cmd_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_seq.sv
// Register-request sequencer in front of the 16-bit SPI master: turns write/read/verify
// requests into framed SPI commands, spaces frames, watches for stalls, returns status.
module spi_cmd_seq #(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [5:0]  addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        rsp_vld,
    output logic [15:0] rsp_data,
    output logic        err,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] data
);

    localparam int unsigned TW = 16;
    localparam int unsigned GW = 8;
    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WV  = 2'b10;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [5:0]      addr_q;
    logic [7:0]      wdata_q;
    logic [1:0]      idx;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;

    // Frame word for position f of the sequence belonging to operation o.
    function automatic logic [15:0] frame(input logic [1:0] o, input logic [1:0] f,
                                          input logic [5:0] a, input logic [7:0] w);
        logic [15:0] fw;
        fw = 16'h0000;
        case (o)
            OP_WR:   fw = {2'b10, a, w};
            OP_RD:   fw = (f == 2'd0) ? {2'b00, a, 8'h00} : 16'h0000;
            OP_WV: begin
                if (f == 2'd0)      fw = {2'b10, a, w};
                else if (f == 2'd1) fw = {2'b00, a, 8'h00};
                else                fw = 16'h0000;
            end
            default: fw = 16'h0000;
        endcase
        return fw;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] o);
        logic [1:0] l;
        case (o)
            OP_RD:   l = 2'd1;
            OP_WV:   l = 2'd2;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            addr_q   <= 6'h00;
            wdata_q  <= 8'h00;
            idx      <= 2'd0;
            tcnt     <= '0;
            gcnt     <= '0;
            busy     <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_data <= 16'h0000;
            err      <= 1'b0;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    cmd <= 16'h0000;
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        if (op == 2'b11) begin
                            state    <= RESP;
                            rsp_vld  <= 1'b1;
                            err      <= 1'b1;
                            rsp_data <= 16'h0000;
                        end else begin
                            state <= ISSUE;
                            wrt   <= 1'b1;
                            cmd   <= frame(op, 2'd0, addr, wdata);
                        end
                    end
                end
                ISSUE: begin
                    wrt   <= 1'b0;
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        if (idx == last_idx(op_q)) begin
                            state   <= RESP;
                            rsp_vld <= 1'b1;
                            cmd     <= 16'h0000;
                            case (op_q)
                                OP_WR: begin
                                    rsp_data <= 16'h0000;
                                    err      <= 1'b0;
                                end
                                OP_RD: begin
                                    rsp_data <= data;
                                    err      <= 1'b0;
                                end
                                default: begin
                                    rsp_data <= data;
                                    err      <= (data[7:0] != wdata_q);
                                end
                            endcase
                        end else begin
                            state <= GAP;
                            gcnt  <= '0;
                            idx   <= idx + 2'd1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Stalled transfer: drop remaining frames and report abort.
                        state    <= RESP;
                        rsp_vld  <= 1'b1;
                        err      <= 1'b1;
                        rsp_data <= 16'h0000;
                        cmd      <= 16'h0000;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gcnt == GW'(GAP_CYC - 1)) begin
                        state <= ISSUE;
                        wrt   <= 1'b1;
                        cmd   <= frame(op_q, idx, addr_q, wdata_q);
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                RESP: begin
                    rsp_vld  <= 1'b0;
                    busy     <= 1'b0;
                    err      <= 1'b0;
                    rsp_data <= 16'h0000;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq: a scoreboard of expected frames and responses
// against an SPI-master responder that answers each wrt with a delayed done.
module tb_spi_cmd_seq;

    localparam int unsigned GAP = 4;
    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n, req, done;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] data;
    logic        busy, rsp_vld, err, wrt;
    logic [15:0] rsp_data, cmd;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } rsp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] exp_cmd_q[$];
    logic [15:0] obs_cmd_q[$];
    rsp_t        exp_rsp_q[$];
    int          wrt_cyc_q[$];
    int          done_cyc_q[$];
    int          acc_cyc, rsp_cyc, n_wrt;
    bit          got_rsp, cmd_moved;
    logic [15:0] obs_rsp_data;
    logic        obs_err, obs_busy_rsp, obs_busy_after;

    spi_cmd_seq #(.GAP_CYC(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .err(err),
        .wrt(wrt), .cmd(cmd), .done(done), .data(data)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected frames and response for one request, from the command formats.
    task automatic model(input logic [1:0] o, input logic [5:0] a, input logic [7:0] w,
                         input logic [15:0] rb);
        case (o)
            2'b00: begin
                exp_cmd_q.push_back({2'b10, a, w});
                exp_rsp_q.push_back(rsp_t'{d: 16'h0000, e: 1'b0});
            end
            2'b01: begin
                exp_cmd_q.push_back({2'b00, a, 8'h00});
                exp_cmd_q.push_back(16'h0000);
                exp_rsp_q.push_back(rsp_t'{d: rb, e: 1'b0});
            end
            2'b10: begin
                exp_cmd_q.push_back({2'b10, a, w});
                exp_cmd_q.push_back({2'b00, a, 8'h00});
                exp_cmd_q.push_back(16'h0000);
                exp_rsp_q.push_back(rsp_t'{d: rb, e: (rb[7:0] != w)});
            end
            default: exp_rsp_q.push_back(rsp_t'{d: 16'h0000, e: 1'b1});
        endcase
    endtask

    // Issue one request and act as the SPI master; dly<0 means never answer.
    task automatic do_req(input logic [1:0] o, input logic [5:0] a, input logic [7:0] w,
                          input logic [15:0] rb, input int dly, input bit toggle);
        int nf, fidx, cnt;
        logic [15:0] held;
        nf   = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : (o == 2'b10) ? 3 : 0;
        fidx = 0;
        cnt  = -1;
        held = 16'h0000;
        model(o, a, w, rb);
        obs_cmd_q.delete();
        wrt_cyc_q.delete();
        done_cyc_q.delete();
        got_rsp = 0; cmd_moved = 0; n_wrt = 0;
        req = 1'b1; op = o; addr = a; wdata = w;
        acc_cyc = cyc;
        step;
        req = 1'b0;
        for (int k = 0; k < 1000 && !got_rsp; k++) begin
            done = 1'b0;
            data = 16'h0000;
            if (wrt) begin
                obs_cmd_q.push_back(cmd);
                wrt_cyc_q.push_back(cyc);
                n_wrt++;
                held = cmd;
                cnt  = dly;
            end else if (cnt > 0) begin
                if (cmd !== held) cmd_moved = 1;
                cnt--;
                if (cnt == 0) begin
                    done = 1'b1;
                    data = (fidx == nf - 1) ? rb : 16'($urandom);
                    done_cyc_q.push_back(cyc);
                    fidx++;
                    cnt = -1;
                end
            end
            if (rsp_vld) begin
                got_rsp      = 1;
                rsp_cyc      = cyc;
                obs_rsp_data = rsp_data;
                obs_err      = err;
                obs_busy_rsp = busy;
            end
            if (toggle && busy && !rsp_vld) begin
                req   = 1'($urandom);
                op    = 2'($urandom);
                addr  = 6'($urandom);
                wdata = 8'($urandom);
            end else begin
                req = 1'b0;
            end
            if (!got_rsp) step;
        end
        req  = 1'b0;
        done = 1'b0;
        if (got_rsp) begin
            step;
            obs_busy_after = busy;
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if ({busy, rsp_vld, rsp_data, err, wrt, cmd} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {busy, rsp_vld, rsp_data, err, wrt, cmd}, 36'h0);
        end
    endtask

    task automatic test_write;
        logic [15:0] e, o;
        rsp_t r;
        do_req(2'b00, 6'h05, 8'hA5, 16'h0000, 40, 1);
        n_tests++;
        if (!got_rsp) begin n_fail++; $display("FAIL write_rsp: got no rsp_vld expected one"); end
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            o = (obs_cmd_q.size() > 0) ? obs_cmd_q.pop_front() : 16'hxxxx;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL write_cmd: got %h expected %h", o, e); end
        end
        n_tests++;
        if (n_wrt != 1) begin n_fail++; $display("FAIL write_nwrt: got %0d expected 1", n_wrt); end
        n_tests++;
        if (rsp_cyc - wrt_cyc_q[0] != 41) begin
            n_fail++; $display("FAIL write_latency: got %0d expected 41", rsp_cyc - wrt_cyc_q[0]);
        end
        r = exp_rsp_q.pop_front();
        n_tests++;
        if ({obs_rsp_data, obs_err} !== r) begin
            n_fail++; $display("FAIL write_rsp_word: got %h/%b expected %h/%b", obs_rsp_data, obs_err, r.d, r.e);
        end
        n_tests++;
        if ({obs_busy_rsp, obs_busy_after} !== 2'b10) begin
            n_fail++; $display("FAIL write_busy: got %b expected 10", {obs_busy_rsp, obs_busy_after});
        end
        n_tests++;
        if (cmd_moved) begin n_fail++; $display("FAIL write_cmd_hold: got moved expected stable"); end
    endtask

    task automatic test_read;
        logic [15:0] e, o;
        rsp_t r;
        do_req(2'b01, 6'h12, 8'h77, 16'h3C7E, 7, 1);
        while (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            o = (obs_cmd_q.size() > 0) ? obs_cmd_q.pop_front() : 16'hxxxx;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL read_cmd: got %h expected %h", o, e); end
        end
        n_tests++;
        if (wrt_cyc_q.size() != 2 || done_cyc_q.size() < 1) begin
            n_fail++; $display("FAIL read_frames: got %0d wrt expected 2", wrt_cyc_q.size());
        end else if (wrt_cyc_q[1] - done_cyc_q[0] - 1 != int'(GAP)) begin
            n_fail++; $display("FAIL read_gap: got %0d expected %0d", wrt_cyc_q[1] - done_cyc_q[0] - 1, GAP);
        end
        r = exp_rsp_q.pop_front();
        n_tests++;
        if (!got_rsp || {obs_rsp_data, obs_err} !== r) begin
            n_fail++; $display("FAIL read_rsp: got %h/%b expected %h/%b", obs_rsp_data, obs_err, r.d, r.e);
        end
        n_tests++;
        if (cmd_moved) begin n_fail++; $display("FAIL read_cmd_hold: got moved expected stable"); end
    endtask

    task automatic test_verify;
        logic [15:0] e, o;
        logic [15:0] rbs [2];
        rsp_t r;
        rbs[0] = 16'h005A;
        rbs[1] = 16'h005B;
        for (int t = 0; t < 2; t++) begin
            do_req(2'b10, 6'h01, 8'h5A, rbs[t], 5 + t, 1);
            while (exp_cmd_q.size() > 0) begin
                e = exp_cmd_q.pop_front();
                o = (obs_cmd_q.size() > 0) ? obs_cmd_q.pop_front() : 16'hxxxx;
                n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL verify_cmd: got %h expected %h", o, e); end
            end
            r = exp_rsp_q.pop_front();
            n_tests++;
            if (!got_rsp || {obs_rsp_data, obs_err} !== r) begin
                n_fail++; $display("FAIL verify_rsp: got %h/%b expected %h/%b", obs_rsp_data, obs_err, r.d, r.e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [15:0] e, o;
        int stray;
        do_req(2'b00, 6'h3F, 8'hFF, 16'h0000, -1, 0);
        void'(exp_rsp_q.pop_front());
        e = exp_cmd_q.pop_front();
        o = (obs_cmd_q.size() > 0) ? obs_cmd_q.pop_front() : 16'hxxxx;
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL timeout_cmd: got %h expected %h", o, e); end
        n_tests++;
        if (!got_rsp || rsp_cyc - wrt_cyc_q[0] != int'(TMO) + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", rsp_cyc - wrt_cyc_q[0], TMO + 1);
        end
        n_tests++;
        if ({obs_rsp_data, obs_err} !== 17'h00001) begin
            n_fail++; $display("FAIL timeout_rsp: got %h/%b expected 0000/1", obs_rsp_data, obs_err);
        end
        done = 1'b1;
        data = 16'hBEEF;
        step;
        done = 1'b0;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_vld || busy) stray++;
            step;
        end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL timeout_stray_done: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_reserved;
        rsp_t r;
        do_req(2'b11, 6'h2A, 8'h11, 16'h0000, 5, 1);
        r = exp_rsp_q.pop_front();
        n_tests++;
        if (!got_rsp || rsp_cyc - acc_cyc != 1) begin
            n_fail++; $display("FAIL reserved_latency: got %0d expected 1", rsp_cyc - acc_cyc);
        end
        n_tests++;
        if (n_wrt != 0) begin n_fail++; $display("FAIL reserved_wrt: got %0d expected 0", n_wrt); end
        n_tests++;
        if ({obs_rsp_data, obs_err} !== r) begin
            n_fail++; $display("FAIL reserved_rsp: got %h/%b expected %h/%b", obs_rsp_data, obs_err, r.d, r.e);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] seq;
        req = 1'b1;
        op  = 2'b11;
        step;
        seq[2] = rsp_vld;
        step;
        seq[1] = rsp_vld | busy;
        step;
        seq[0] = rsp_vld;
        req = 1'b0;
        step;
        step;
        n_tests++;
        if (seq !== 3'b101) begin n_fail++; $display("FAIL held_req_seq: got %b expected 101", seq); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] e, o;
        int stray;
        rsp_t r;
        req = 1'b1; op = 2'b00; addr = 6'h2A; wdata = 8'h3C;
        step;
        req = 1'b0;
        for (int k = 0; k < 5; k++) step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        n_tests++;
        if ({busy, rsp_vld, rsp_data, err, wrt, cmd} !== 36'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h expected %h",
                               {busy, rsp_vld, rsp_data, err, wrt, cmd}, 36'h0);
        end
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            if (rsp_vld) stray++;
        end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL midreset_rsp: got %0d expected 0", stray); end
        do_req(2'b00, 6'h2A, 8'h3C, 16'h0000, 3, 0);
        e = exp_cmd_q.pop_front();
        o = (obs_cmd_q.size() > 0) ? obs_cmd_q.pop_front() : 16'hxxxx;
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL midreset_cmd: got %h expected %h", o, e); end
        r = exp_rsp_q.pop_front();
        n_tests++;
        if (!got_rsp || {obs_rsp_data, obs_err} !== r) begin
            n_fail++; $display("FAIL midreset_rsp_word: got %h/%b expected %h/%b", obs_rsp_data, obs_err, r.d, r.e);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; done = 1'b0; data = 16'h0000;
        op = 2'b00; addr = 6'h00; wdata = 8'h00;
        step; step; step;
        test_reset;
        rst_n = 1'b1;
        step;
        test_write;
        test_read;
        test_verify;
        test_timeout;
        test_reserved;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
